// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: central pipeline sequencer for the five-stage MIPS core.
// Drives PC / IF/ID / ID/EX / EX/MEM / MEM/WB write enables, flushes and the
// MEM/WB bubble; resolves load-use, taken-branch and data-memory waits.
// Ports: clk, rst (sync, active-high); IFID_Rs/Rt, IDEX_MemRead/Rt,
//   EX_BranchTaken, EXMEM_MemRead/MemWrite, dmem_ready in;
//   dmem_req, *_write, IFID_flush, IDEX_flush, MEMWB_bubble,
//   mem_timeout_err, stall_cnt, flush_cnt out.
// Optional: define HAZARD_PERF_CNT_EN to build the stall/flush counters.
module pipe_hazard_ctrl #(
   parameter int CNT_W       = 16,
   parameter int MEM_TIMEOUT = 15
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [4:0]       IFID_Rs,
   input  logic [4:0]       IFID_Rt,
   input  logic             IDEX_MemRead,
   input  logic [4:0]       IDEX_Rt,
   input  logic             EX_BranchTaken,
   input  logic             EXMEM_MemRead,
   input  logic             EXMEM_MemWrite,
   input  logic             dmem_ready,
   output logic             dmem_req,
   output logic             PC_write,
   output logic             IFID_write,
   output logic             IDEX_write,
   output logic             EXMEM_write,
   output logic             MEMWB_write,
   output logic             IFID_flush,
   output logic             IDEX_flush,
   output logic             MEMWB_bubble,
   output logic             mem_timeout_err,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int WC_W = $clog2(MEM_TIMEOUT + 1);
   localparam logic [WC_W-1:0] WC_MAX = WC_W'(MEM_TIMEOUT);

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MEM_ERR  = 2'd2
   } state_e;

   state_e          state_q, state_d;
   logic [WC_W-1:0] wcnt_q, wcnt_d;
   logic            err_q, err_d;
   logic            mem_op;
   logic            load_use;
   logic            frozen;

   always_comb begin
      mem_op   = EXMEM_MemRead | EXMEM_MemWrite;
      load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                 ((IDEX_Rt == IFID_Rs) || (IDEX_Rt == IFID_Rt));
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= RUN;
         wcnt_q  <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         err_q   <= err_d;
      end
   end

   // Next-state logic; wcnt holds the stall cycle number while waiting
   always_comb begin
      state_d = state_q;
      wcnt_d  = wcnt_q;
      unique case (state_q)
         RUN: begin
            if (mem_op && !dmem_ready) begin
               state_d = MEM_WAIT;
               wcnt_d  = WC_W'(1);
            end
         end
         MEM_WAIT: begin
            if (dmem_ready) begin
               state_d = RUN;
            end else if (wcnt_q == WC_MAX) begin
               state_d = MEM_ERR;
            end else begin
               wcnt_d = wcnt_q + 1'b1;
            end
         end
         MEM_ERR: state_d = MEM_ERR;
         default: state_d = RUN;
      endcase
      err_d = err_q | (state_d == MEM_ERR);
   end

   // Mealy outputs; memory stall beats branch, branch beats load-use
   always_comb begin
      dmem_req     = 1'b0;
      frozen       = 1'b0;
      PC_write     = 1'b1;
      IFID_write   = 1'b1;
      IDEX_write   = 1'b1;
      EXMEM_write  = 1'b1;
      MEMWB_write  = 1'b1;
      IFID_flush   = 1'b0;
      IDEX_flush   = 1'b0;
      MEMWB_bubble = 1'b0;
      unique case (state_q)
         RUN: begin
            dmem_req = mem_op;
            frozen   = mem_op && !dmem_ready;
         end
         MEM_WAIT: begin
            dmem_req = 1'b1;
            frozen   = !dmem_ready;
         end
         MEM_ERR: frozen = 1'b1;
         default: frozen = 1'b1;
      endcase
      if (frozen) begin
         PC_write     = 1'b0;
         IFID_write   = 1'b0;
         IDEX_write   = 1'b0;
         EXMEM_write  = 1'b0;
         MEMWB_write  = 1'b0;
         MEMWB_bubble = 1'b1;
      end else if (EX_BranchTaken) begin
         IFID_flush = 1'b1;
         IDEX_flush = 1'b1;
      end else if (load_use) begin
         PC_write   = 1'b0;
         IFID_write = 1'b0;
         IDEX_flush = 1'b1;
      end
      if (rst) begin
         dmem_req     = 1'b0;
         PC_write     = 1'b0;
         IFID_write   = 1'b0;
         IDEX_write   = 1'b0;
         EXMEM_write  = 1'b0;
         MEMWB_write  = 1'b0;
         IFID_flush   = 1'b1;
         IDEX_flush   = 1'b1;
         MEMWB_bubble = 1'b1;
      end
   end

   assign mem_timeout_err = err_q;

`ifdef HAZARD_PERF_CNT_EN
   logic [CNT_W-1:0] stall_q, stall_d;
   logic [CNT_W-1:0] flush_q, flush_d;

   // Saturating counters
   always_comb begin
      stall_d = stall_q;
      flush_d = flush_q;
      if (!PC_write && !(&stall_q)) stall_d = stall_q + 1'b1;
      if (IFID_flush && !(&flush_q)) flush_d = flush_q + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stall_q <= '0;
         flush_q <= '0;
      end else begin
         stall_q <= stall_d;
         flush_q <= flush_d;
      end
   end

   assign stall_cnt = stall_q;
   assign flush_cnt = flush_q;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule

// File: doc/pipe_hazard_ctrl.md
# pipe_hazard_ctrl

Central pipeline sequencer for the five-stage MIPS core. Drives the write-enable, flush and bubble controls of the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB stage registers. Resolves load-use hazards, taken-branch flushes and multi-cycle data-memory waits through a `dmem_req`/`dmem_ready` handshake. Sits beside the datapath and consumes only stage-register fields.

## Interface
Parameters:
- `CNT_W`, 16: width of the performance counters.
- `MEM_TIMEOUT`, 15: maximum wait cycles after the request cycle before a memory error; must be ≥1.

Ports:
- `clk` in 1: single clock, all state on the rising edge.
- `rst` in 1: synchronous reset, active-high.
- `IFID_Rs`, `IFID_Rt` in 5 each: source registers of the instruction in decode.
- `IDEX_MemRead` in 1, `IDEX_Rt` in 5: load flag and destination of the instruction in EX.
- `EX_BranchTaken` in 1: branch resolved taken in EX.
- `EXMEM_MemRead`, `EXMEM_MemWrite` in 1: memory operation in the MEM stage.
- `dmem_ready` in 1: data memory completes the access this cycle.
- `dmem_req` out 1: memory access request.
- `PC_write`, `IFID_write`, `IDEX_write`, `EXMEM_write`, `MEMWB_write` out 1: stage-register load enables.
- `IFID_flush`, `IDEX_flush` out 1: load zeros (bubble) into IF/ID or ID/EX.
- `MEMWB_bubble` out 1: load zeros into MEM/WB; takes precedence over `MEMWB_write`.
- `mem_timeout_err` out 1: sticky memory-timeout flag.
- `stall_cnt`, `flush_cnt` out `CNT_W`: performance counters; see Configuration.

## Operation
- FSM states: `RUN`, `MEM_WAIT`, `MEM_ERR`. Outputs are Mealy functions of the state and the current inputs.
- `rst` high: state goes to `RUN`, the wait counter and error flag clear, and the counters clear. In that same cycle the outputs are forced:
  - all write enables 0;
  - `IFID_flush`, `IDEX_flush` and `MEMWB_bubble` 1;
  - `dmem_req` 0.
- Define `mem_op = EXMEM_MemRead | EXMEM_MemWrite`.
- `RUN` with `mem_op` asserted:
  - `dmem_req` is 1.
  - If `dmem_ready` is 1, the access completes with no stall.
  - If `dmem_ready` is 0: all write enables are 0, `MEMWB_bubble` is 1, the wait counter loads 1, and the next state is `MEM_WAIT`.
- `MEM_WAIT`:
  - `dmem_req` is 1; all write enables are 0; `MEMWB_bubble` is 1.
  - On `dmem_ready`: release cycle. All write enables are 1, `MEMWB_bubble` is 0, and the next state is `RUN`. Load-use and branch rules also apply in this cycle.
  - Otherwise, if the wait counter equals `MEM_TIMEOUT`, the next state is `MEM_ERR`; if not, the counter increments.
- `MEM_ERR`:
  - `dmem_req` is 0; all enables are 0; `MEMWB_bubble` is 1; `mem_timeout_err` is 1.
  - The state is held until `rst`.
- Load-use hazard: `IDEX_MemRead && IDEX_Rt != 0 && (IDEX_Rt == IFID_Rs || IDEX_Rt == IFID_Rt)`.
  - Response when no memory stall is active: `PC_write=0`, `IFID_write=0`, `IDEX_flush=1`.
- Branch taken (no memory stall): `IFID_flush=1`, `IDEX_flush=1`, `PC_write=1`.
- Priority: memory stall > branch > load-use. On a branch the load-use stall is suppressed.
- Default in `RUN` with no hazard: all write enables 1, all flushes and `MEMWB_bubble` 0.

## Timing
- Zero-cycle control latency: hazard outputs respond combinationally in the same cycle as their inputs.
- Only the FSM state, the wait counter, the error flag and the counters are registered.
- Memory-stall cycle numbering:
  - cycle 0 is the first `RUN` cycle with `mem_op=1` and `dmem_ready=0`;
  - `MEM_WAIT` occupies cycles 1..`MEM_TIMEOUT`;
  - if `dmem_ready` is not seen by cycle `MEM_TIMEOUT`, `MEM_ERR` begins at cycle `MEM_TIMEOUT`+1.
- `dmem_ready` arriving in cycle `MEM_TIMEOUT` is accepted as a normal release.
- While frozen, the EX and MEM inputs are stable because their stage registers hold. A branch pending during a stall therefore takes effect in the release cycle.
- Reset asserted mid-wait takes effect at the next edge. `dmem_req` drops in the reset cycle itself.

## Configuration
- `HAZARD_PERF_CNT_EN` defined:
  - `stall_cnt` increments on every non-reset cycle with `PC_write=0`.
  - `flush_cnt` increments on every non-reset cycle with `IFID_flush=1`.
  - Both saturate at all-ones and clear on `rst`.
- Not defined: both ports are driven constant 0 and no counter flops are built.

## Test plan
- Reset: `rst=1` for 1 cycle → all enables 0, flushes and `MEMWB_bubble` 1, `dmem_req=0`, `mem_timeout_err=0`, counters 0.
- Load-use: `IDEX_MemRead=1`, `IDEX_Rt=5`, `IFID_Rs=5` → `PC_write=0`, `IFID_write=0`, `IDEX_flush=1` for exactly that cycle. Repeat with `IDEX_Rt=0` → no stall.
- Branch plus load-use in the same cycle → `IFID_flush=1`, `IDEX_flush=1`, `PC_write=1`, `IFID_write=1`.
- Memory wait: `EXMEM_MemRead=1`, `dmem_ready` rises at cycle 3 → enables 0 and `MEMWB_bubble=1` in cycles 0–2, release in cycle 3, `stall_cnt=3` (macro on).
- Timeout with `MEM_TIMEOUT=4` and `dmem_ready` never asserted:
  - `mem_timeout_err=1` and `dmem_req=0` from cycle 5 until `rst`;
  - a second run with ready at cycle 4 → normal release.
- Counter saturation with `CNT_W=4`: 20 stall cycles → `stall_cnt=15`. With the macro off → `stall_cnt=0` throughout.
